// File: rtl/parallel_match_pipe_if.sv
// ----------------------------------------------------------------------------
// parallel_match_pipe_if
// Groups the candidate-set input handshake and the match-result handshake
// of parallel_match_pipe into one bundle.
//
//   master modport : the side that supplies candidate sets and consumes results
//   slave  modport : the parallel_match_pipe datapath itself
//
// Signals
//   d_val / d_rdy   candidate-set handshake
//   d_bus           DATA_NUM packed candidates, entry i at [i*DATA_WIDTH +: DATA_WIDTH]
//   ref_d           reference word
//   cmp_mask        1 = bit takes part in the compare
//   d_cnt           number of valid candidates (values above DATA_NUM saturate)
//   prio_hi         0 = lowest matching index wins, 1 = highest wins
//   res_val/res_rdy result handshake
//   res_hit, res_multi, res_idx  match result
//   res_vec, res_num             hit vector and hit count (PMATCH_HIT_VEC_EN only)
//
// Optional feature macro: PMATCH_HIT_VEC_EN
// ----------------------------------------------------------------------------
interface parallel_match_pipe_if #(
  parameter int DATA_NUM   = 8,
  parameter int DATA_WIDTH = 42,
  parameter int IDX_WIDTH  = 3,
  parameter int CNT_WIDTH  = 4
);
  logic                           d_val;
  logic                           d_rdy;
  logic [DATA_NUM*DATA_WIDTH-1:0] d_bus;
  logic [DATA_WIDTH-1:0]          ref_d;
  logic [DATA_WIDTH-1:0]          cmp_mask;
  logic [CNT_WIDTH-1:0]           d_cnt;
  logic                           prio_hi;
  logic                           res_val;
  logic                           res_rdy;
  logic                           res_hit;
  logic                           res_multi;
  logic [IDX_WIDTH-1:0]           res_idx;
`ifdef PMATCH_HIT_VEC_EN
  logic [DATA_NUM-1:0]            res_vec;
  logic [CNT_WIDTH-1:0]           res_num;

  modport master (
    output d_val, d_bus, ref_d, cmp_mask, d_cnt, prio_hi, res_rdy,
    input  d_rdy, res_val, res_hit, res_multi, res_idx, res_vec, res_num
  );

  modport slave (
    input  d_val, d_bus, ref_d, cmp_mask, d_cnt, prio_hi, res_rdy,
    output d_rdy, res_val, res_hit, res_multi, res_idx, res_vec, res_num
  );
`else
  modport master (
    output d_val, d_bus, ref_d, cmp_mask, d_cnt, prio_hi, res_rdy,
    input  d_rdy, res_val, res_hit, res_multi, res_idx
  );

  modport slave (
    input  d_val, d_bus, ref_d, cmp_mask, d_cnt, prio_hi, res_rdy,
    output d_rdy, res_val, res_hit, res_multi, res_idx
  );
`endif
endinterface

// File: rtl/parallel_match_pipe.sv
// ----------------------------------------------------------------------------
// parallel_match_pipe
// Compares one reference word against DATA_NUM candidate words in parallel
// (exact or bit-masked), keeps only the first d_cnt candidates, and returns
// hit / priority index / multi-hit through a two-stage valid/ready pipeline.
//
// Ports
//   clk  in  rising-edge clock
//   rst  in  asynchronous, active-high reset
//   pif  parallel_match_pipe_if.slave (see interface header for signal list)
//
// Pipeline
//   stage 1 : registered hit vector hv = match & vmask, plus prio_hi
//   stage 2 : registered result (res_hit, res_multi, res_idx[, res_vec, res_num])
//   Latency 2 cycles, throughput 1 set per cycle.
//
// Optional feature macro: PMATCH_HIT_VEC_EN
//   defined   -> res_vec (registered hv) and res_num (registered popcount(hv))
//   undefined -> those ports and their registers are absent
// ----------------------------------------------------------------------------
module parallel_match_pipe #(
  parameter int DATA_NUM   = 8,
  parameter int DATA_WIDTH = 42,
  parameter int IDX_WIDTH  = 3,
  parameter int CNT_WIDTH  = 4
) (
  input logic                 clk,
  input logic                 rst,
  parallel_match_pipe_if.slave pif
);

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [IDX_WIDTH-1:0] lowest_idx(input logic [DATA_NUM-1:0] v);
    lowest_idx = '0;
    for (int i = DATA_NUM - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = IDX_WIDTH'(i);
    end
  endfunction

  // Index of the highest set bit; 0 when the vector is empty.
  function automatic logic [IDX_WIDTH-1:0] highest_idx(input logic [DATA_NUM-1:0] v);
    highest_idx = '0;
    for (int i = 0; i < DATA_NUM; i++) begin
      if (v[i]) highest_idx = IDX_WIDTH'(i);
    end
  endfunction

  // Number of set bits; CNT_WIDTH is wide enough to hold DATA_NUM.
  function automatic logic [CNT_WIDTH-1:0] popcount(input logic [DATA_NUM-1:0] v);
    popcount = '0;
    for (int i = 0; i < DATA_NUM; i++) begin
      popcount = popcount + CNT_WIDTH'(v[i]);
    end
  endfunction

  logic                  adv;
  logic                  d_rdy;

  logic [DATA_NUM-1:0]   match_p0;
  logic [DATA_NUM-1:0]   vmask_p0;
  logic [DATA_NUM-1:0]   hv_p0;

  logic                  s1_vld_q,     s1_vld_d;
  logic [DATA_NUM-1:0]   hv_p1_q,      hv_p1_d;
  logic                  prio_p1_q,    prio_p1_d;

  logic                  res_val_q,    res_val_d;
  logic                  hit_p2_q,     hit_p2_d;
  logic                  multi_p2_q,   multi_p2_d;
  logic [IDX_WIDTH-1:0]  idx_p2_q,     idx_p2_d;
`ifdef PMATCH_HIT_VEC_EN
  logic [DATA_NUM-1:0]   vec_p2_q,     vec_p2_d;
  logic [CNT_WIDTH-1:0]  num_p2_q,     num_p2_d;
`endif

  logic [CNT_WIDTH-1:0]  pop_p1;
  assign pop_p1 = popcount(hv_p1_q);

  // Stage 2 may take a new value whenever it is empty or being drained.
  // d_rdy depends only on pipeline state and res_rdy, never on d_val.
  assign adv   = ~res_val_q | pif.res_rdy;
  assign d_rdy = ~s1_vld_q | adv;

  // ---- stage 0 -> 1 : parallel masked compare and valid-count filter ----
  // Entries at index >= DATA_NUM do not exist, so any d_cnt above DATA_NUM
  // naturally enables every entry.
  always_comb begin
    match_p0 = '0;
    vmask_p0 = '0;
    for (int i = 0; i < DATA_NUM; i++) begin
      match_p0[i] = ~|((pif.d_bus[i*DATA_WIDTH +: DATA_WIDTH] ^ pif.ref_d) & pif.cmp_mask);
      vmask_p0[i] = (CNT_WIDTH'(i) < pif.d_cnt);
    end
    hv_p0 = match_p0 & vmask_p0;
  end

  always_comb begin
    s1_vld_d  = s1_vld_q;
    hv_p1_d   = hv_p1_q;
    prio_p1_d = prio_p1_q;
    // When stage 1 is ready its content either moves on or is empty, so its
    // valid simply follows d_val; data is only captured on an actual accept.
    if (d_rdy) begin
      s1_vld_d = pif.d_val;
    end
    if (pif.d_val && d_rdy) begin
      hv_p1_d   = hv_p0;
      prio_p1_d = pif.prio_hi;
    end
  end

  // ---- stage 1 -> 2 : reduce hit vector to result ----
  always_comb begin
    res_val_d  = res_val_q;
    hit_p2_d   = hit_p2_q;
    multi_p2_d = multi_p2_q;
    idx_p2_d   = idx_p2_q;
`ifdef PMATCH_HIT_VEC_EN
    vec_p2_d   = vec_p2_q;
    num_p2_d   = num_p2_q;
`endif
    if (adv) begin
      res_val_d = s1_vld_q;
      // Result fields only change when a real set arrives, so a bubble never
      // disturbs the last delivered values.
      if (s1_vld_q) begin
        hit_p2_d   = |hv_p1_q;
        multi_p2_d = (pop_p1 >= CNT_WIDTH'(2));
        idx_p2_d   = prio_p1_q ? highest_idx(hv_p1_q) : lowest_idx(hv_p1_q);
`ifdef PMATCH_HIT_VEC_EN
        vec_p2_d   = hv_p1_q;
        num_p2_d   = pop_p1;
`endif
      end
    end
  end

  // Control and visible outputs: asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q   <= 1'b0;
      res_val_q  <= 1'b0;
      hit_p2_q   <= 1'b0;
      multi_p2_q <= 1'b0;
      idx_p2_q   <= '0;
`ifdef PMATCH_HIT_VEC_EN
      vec_p2_q   <= '0;
      num_p2_q   <= '0;
`endif
    end else begin
      s1_vld_q   <= s1_vld_d;
      res_val_q  <= res_val_d;
      hit_p2_q   <= hit_p2_d;
      multi_p2_q <= multi_p2_d;
      idx_p2_q   <= idx_p2_d;
`ifdef PMATCH_HIT_VEC_EN
      vec_p2_q   <= vec_p2_d;
      num_p2_q   <= num_p2_d;
`endif
    end
  end

  // Stage 1 payload is qualified by s1_vld_q and needs no reset.
  always_ff @(posedge clk) begin
    hv_p1_q   <= hv_p1_d;
    prio_p1_q <= prio_p1_d;
  end

  assign pif.d_rdy     = d_rdy;
  assign pif.res_val   = res_val_q;
  assign pif.res_hit   = hit_p2_q;
  assign pif.res_multi = multi_p2_q;
  assign pif.res_idx   = idx_p2_q;
`ifdef PMATCH_HIT_VEC_EN
  assign pif.res_vec   = vec_p2_q;
  assign pif.res_num   = num_p2_q;
`endif

endmodule

// File: tb/tb_parallel_match_pipe.sv
// ----------------------------------------------------------------------------
// tb_parallel_match_pipe
// Directed bench for parallel_match_pipe (DATA_NUM=8, DATA_WIDTH=42).
// Inputs change on the falling edge; outputs are checked on the falling edge.
// ----------------------------------------------------------------------------
module tb_parallel_match_pipe;
  localparam int DN = 8;
  localparam int DW = 42;
  localparam int IW = 3;
  localparam int CW = 4;

  localparam logic [DW-1:0] REF   = 42'h2AB_CDEF_0123;
  localparam logic [DW-1:0] ONES  = '1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  parallel_match_pipe_if #(.DATA_NUM(DN), .DATA_WIDTH(DW), .IDX_WIDTH(IW), .CNT_WIDTH(CW)) bus ();

  parallel_match_pipe #(.DATA_NUM(DN), .DATA_WIDTH(DW), .IDX_WIDTH(IW), .CNT_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .pif (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Matching entries equal REF; others differ in a low bit (never 0 since i+1>0).
  // bit20_e3 puts entry 3 at REF with only bit 20 flipped.
  task automatic drive_set(input logic [DN-1:0] mbits, input logic [CW-1:0] cnt,
                           input logic [DW-1:0] mask, input logic prio, input bit bit20_e3);
    logic [DW-1:0] e;
    for (int i = 0; i < DN; i++) begin
      e = mbits[i] ? REF : (REF ^ DW'(i + 1));
      if (bit20_e3 && i == 3) e = REF ^ (DW'(1) << 20);
      bus.d_bus[i*DW +: DW] = e;
    end
    bus.ref_d    = REF;
    bus.cmp_mask = mask;
    bus.d_cnt    = cnt;
    bus.prio_hi  = prio;
  endtask

  // One set through an idle pipe, res_rdy held high.
  task automatic send_chk(input string tag, input logic [DN-1:0] mbits, input logic [CW-1:0] cnt,
                          input logic [DW-1:0] mask, input logic prio, input bit bit20_e3,
                          input logic ehit, input logic emulti, input logic [IW-1:0] eidx,
                          input logic [DN-1:0] evec, input logic [CW-1:0] enum_);
    @(negedge clk);
    drive_set(mbits, cnt, mask, prio, bit20_e3);
    bus.d_val = 1'b1;
    #1;
    chk({tag, "/d_rdy"}, 64'(bus.d_rdy), 64'd1);
    @(negedge clk);
    bus.d_val = 1'b0;
    chk({tag, "/val_lat1"}, 64'(bus.res_val), 64'd0);
    @(negedge clk);
    chk({tag, "/val"},   64'(bus.res_val),   64'd1);
    chk({tag, "/hit"},   64'(bus.res_hit),   64'(ehit));
    chk({tag, "/multi"}, 64'(bus.res_multi), 64'(emulti));
    chk({tag, "/idx"},   64'(bus.res_idx),   64'(eidx));
`ifdef PMATCH_HIT_VEC_EN
    chk({tag, "/vec"},   64'(bus.res_vec),   64'(evec));
    chk({tag, "/num"},   64'(bus.res_num),   64'(enum_));
`else
    if (evec != evec || enum_ != enum_) $display("unused");
`endif
  endtask

  logic [DN-1:0] stream_m [4];
  logic [IW-1:0] stream_i [4];
  int            sent;
  int            rcv;
  logic [IW-1:0] held_idx;

  initial begin
    bus.d_val    = 1'b0;
    bus.res_rdy  = 1'b1;
    bus.d_bus    = '0;
    bus.ref_d    = '0;
    bus.cmp_mask = '0;
    bus.d_cnt    = '0;
    bus.prio_hi  = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst/res_val",   64'(bus.res_val),   64'd0);
    chk("rst/res_hit",   64'(bus.res_hit),   64'd0);
    chk("rst/res_multi", 64'(bus.res_multi), 64'd0);
    chk("rst/res_idx",   64'(bus.res_idx),   64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst/d_rdy", 64'(bus.d_rdy), 64'd1);
    chk("rst/idle_val", 64'(bus.res_val), 64'd0);

    // Single match at entry 5, both priorities
    send_chk("t1_p0", 8'h20, 4'd8, ONES, 1'b0, 1'b0, 1'b1, 1'b0, 3'd5, 8'h20, 4'd1);
    send_chk("t1_p1", 8'h20, 4'd8, ONES, 1'b1, 1'b0, 1'b1, 1'b0, 3'd5, 8'h20, 4'd1);
    // Entries 2 and 6
    send_chk("t2_p0", 8'h44, 4'd8, ONES, 1'b0, 1'b0, 1'b1, 1'b1, 3'd2, 8'h44, 4'd2);
    send_chk("t2_p1", 8'h44, 4'd8, ONES, 1'b1, 1'b0, 1'b1, 1'b1, 3'd6, 8'h44, 4'd2);
    // Valid-count filter on entry 6
    send_chk("t3_c6",  8'h40, 4'd6,  ONES, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 4'd0);
    send_chk("t3_c7",  8'h40, 4'd7,  ONES, 1'b0, 1'b0, 1'b1, 1'b0, 3'd6, 8'h40, 4'd1);
    send_chk("t3_c15", 8'h40, 4'd15, ONES, 1'b0, 1'b0, 1'b1, 1'b0, 3'd6, 8'h40, 4'd1);
    // d_cnt=0 with every entry matching
    send_chk("cnt0", 8'hFF, 4'd0, ONES, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 4'd0);
    // cmp_mask=0 matches all valid entries (0..4)
    send_chk("mask0_p0", 8'h00, 4'd5, '0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 8'h1F, 4'd5);
    send_chk("mask0_p1", 8'h00, 4'd5, '0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd4, 8'h1F, 4'd5);
    // Low-byte mask: entry 3 differs only in bit 20
    send_chk("t4", 8'h00, 4'd8, 42'h0FF, 1'b0, 1'b1, 1'b1, 1'b0, 3'd3, 8'h08, 4'd1);

    // Streaming with backpressure: 4 sets, res_rdy low in cycles 2..4
    stream_m[0] = 8'h02; stream_i[0] = 3'd1;
    stream_m[1] = 8'h08; stream_i[1] = 3'd3;
    stream_m[2] = 8'h20; stream_i[2] = 3'd5;
    stream_m[3] = 8'h80; stream_i[3] = 3'd7;
    sent = 0;
    rcv  = 0;
    held_idx = '0;
    @(negedge clk);
    for (int cyc = 0; cyc < 20; cyc++) begin
      bus.res_rdy = !(cyc >= 2 && cyc <= 4);
      bus.d_val   = (sent < 4);
      if (sent < 4) drive_set(stream_m[sent], 4'd8, ONES, 1'b0, 1'b0);
      #1;
      if (cyc == 2) begin
        chk("t5/d_rdy_stall", 64'(bus.d_rdy), 64'd0);
        chk("t5/sent_at_stall", 64'(sent), 64'd2);
        held_idx = bus.res_idx;
      end
      if (cyc == 3 || cyc == 4) begin
        chk("t5/hold_val", 64'(bus.res_val), 64'd1);
        chk("t5/hold_idx", 64'(bus.res_idx), 64'(held_idx));
      end
      if (bus.res_val && bus.res_rdy) begin
        if (rcv < 4) begin
          chk("t5/res_idx", 64'(bus.res_idx), 64'(stream_i[rcv]));
          chk("t5/res_hit", 64'(bus.res_hit), 64'd1);
          chk("t5/res_multi", 64'(bus.res_multi), 64'd0);
        end
        rcv++;
      end
      if (bus.d_val && bus.d_rdy) sent++;
      @(negedge clk);
    end
    bus.d_val   = 1'b0;
    bus.res_rdy = 1'b1;
    chk("t5/sent", 64'(sent), 64'd4);
    chk("t5/received", 64'(rcv), 64'd4);

    // Async reset with both stages full
    bus.res_rdy = 1'b0;
    drive_set(8'h01, 4'd8, ONES, 1'b0, 1'b0);
    bus.d_val = 1'b1;
    @(negedge clk);
    drive_set(8'h04, 4'd8, ONES, 1'b0, 1'b0);
    @(negedge clk);
    bus.d_val = 1'b0;
    #1;
    chk("t6/full_val", 64'(bus.res_val), 64'd1);
    chk("t6/full_rdy", 64'(bus.d_rdy), 64'd0);
    #1;
    rst = 1'b1;
    #1;
    chk("t6/async_val", 64'(bus.res_val), 64'd0);
    chk("t6/async_hit", 64'(bus.res_hit), 64'd0);
    chk("t6/async_idx", 64'(bus.res_idx), 64'd0);
    chk("t6/async_rdy", 64'(bus.d_rdy), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    bus.res_rdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t6/no_stale", 64'(bus.res_val), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
